// File: rtl/stopwatch_ctrl.sv
// Stopwatch key debounce and start/pause/lap/clear control.
// Drives counter enable/clear and the live-or-lap display select.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        key_ss_n,
  input  logic        key_lr_n,
  input  logic [11:0] ms_in,
  input  logic [7:0]  sec_in,
  input  logic [3:0]  min_in,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic [11:0] disp_ms,
  output logic [7:0]  disp_sec,
  output logic [3:0]  disp_min,
  output logic [1:0]  state,
  output logic [3:0]  lap_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    LAP    = 2'd3
  } state_t;

  // bit 0 = start/stop key, bit 1 = lap/reset key
  logic [1:0]    s1, s2, db, db_d, ev;
  logic [CW-1:0] cnt [2];

  state_t      st, st_d;
  logic        en_d, clr_d, cap;
  logic [3:0]  lap_d;
  logic [11:0] snap_ms;
  logic [7:0]  snap_sec;
  logic [3:0]  snap_min;

  // Synchronize, debounce and turn debounced falls into press pulses
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      s1     <= 2'b11;
      s2     <= 2'b11;
      db     <= 2'b11;
      db_d   <= 2'b11;
      ev     <= 2'b00;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1   <= {key_lr_n, key_ss_n};
      s2   <= s1;
      db_d <= db;
      ev   <= db_d & ~db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          db[i]  <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next state, counter controls and lap bookkeeping
  always_comb begin
    st_d  = st;
    clr_d = 1'b0;
    cap   = 1'b0;
    lap_d = lap_cnt;
    unique case (st)
      IDLE: begin
        if (ev[0]) begin
          st_d = RUN;
        end else if (ev[1]) begin
          clr_d = 1'b1;
          lap_d = 4'd0;
        end
      end
      RUN: begin
        if (ev[0]) begin
          st_d = PAUSED;
        end else if (ev[1]) begin
          st_d  = LAP;
          cap   = 1'b1;
          lap_d = (lap_cnt == 4'd15) ? 4'd15 : lap_cnt + 4'd1;
        end
      end
      LAP: begin
        if (ev[0]) begin
          st_d = PAUSED;
        end else if (ev[1]) begin
          st_d = RUN;
        end
      end
      PAUSED: begin
        if (ev[0]) begin
          st_d = RUN;
        end else if (ev[1]) begin
          st_d  = IDLE;
          clr_d = 1'b1;
          lap_d = 4'd0;
        end
      end
      default: st_d = IDLE;
    endcase
    en_d = (st_d == RUN) || (st_d == LAP);
  end

  // Registered FSM state, outputs and lap snapshot
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      lap_cnt  <= 4'd0;
      snap_ms  <= '0;
      snap_sec <= '0;
      snap_min <= '0;
    end else begin
      st      <= st_d;
      cnt_en  <= en_d;
      cnt_clr <= clr_d;
      lap_cnt <= lap_d;
      if (cap) begin
        snap_ms  <= ms_in;
        snap_sec <= sec_in;
        snap_min <= min_in;
      end
    end
  end

  // Show the frozen lap while in LAP, otherwise the live count
  always_comb begin
    state    = st;
    disp_ms  = ms_in;
    disp_sec = sec_in;
    disp_min = min_in;
    if (st == LAP) begin
      disp_ms  = snap_ms;
      disp_sec = snap_sec;
      disp_min = snap_min;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle debounce.
// Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_ctrl;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        key_ss_n = 1'b1;
  logic        key_lr_n = 1'b1;
  logic [11:0] ms_in = 12'd0;
  logic [7:0]  sec_in = 8'd0;
  logic [3:0]  min_in = 4'd0;
  logic        cnt_en, cnt_clr;
  logic [11:0] disp_ms;
  logic [7:0]  disp_sec;
  logic [3:0]  disp_min;
  logic [1:0]  state;
  logic [3:0]  lap_cnt;

  int n_chk = 0;
  int n_fail = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .key_ss_n(key_ss_n),
    .key_lr_n(key_lr_n),
    .ms_in   (ms_in),
    .sec_in  (sec_in),
    .min_in  (min_in),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .disp_ms (disp_ms),
    .disp_sec(disp_sec),
    .disp_min(disp_min),
    .state   (state),
    .lap_cnt (lap_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic do_reset();
    @(negedge clk_50M);
    rst = 1'b1;
    key_ss_n = 1'b1;
    key_lr_n = 1'b1;
    repeat (2) @(negedge clk_50M);
    rst = 1'b0;
    @(negedge clk_50M);
  endtask

  task automatic press(input bit lr);
    @(negedge clk_50M);
    if (lr) key_lr_n = 1'b0;
    else key_ss_n = 1'b0;
    repeat (8) @(posedge clk_50M);
    @(negedge clk_50M);
    key_lr_n = 1'b1;
    key_ss_n = 1'b1;
    repeat (8) @(posedge clk_50M);
    @(negedge clk_50M);
  endtask

  task automatic test_reset();
    ms_in = 12'd7;
    sec_in = 8'd8;
    min_in = 4'd9;
    rst = 1'b1;
    repeat (2) @(negedge clk_50M);
    n_chk++;
    if ({state, cnt_en, cnt_clr, lap_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outs got st=%0d en=%0b clr=%0b lap=%0d want 0",
               state, cnt_en, cnt_clr, lap_cnt);
    end
    n_chk++;
    if ({disp_ms, disp_sec, disp_min} !== {12'd7, 8'd8, 4'd9}) begin
      n_fail++;
      $display("FAIL reset_disp got %0d/%0d/%0d want 7/8/9",
               disp_ms, disp_sec, disp_min);
    end
    rst = 1'b0;
    @(negedge clk_50M);
  endtask

  task automatic test_start_latency();
    key_ss_n = 1'b0;
    repeat (7) @(posedge clk_50M);
    #1;
    n_chk++;
    if (state !== 2'd0 || cnt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early got st=%0d en=%0b want 0/0", state, cnt_en);
    end
    @(posedge clk_50M);
    #1;
    n_chk++;
    if (state !== 2'd1 || cnt_en !== 1'b1) begin
      n_fail++;
      $display("FAIL start_edge got st=%0d en=%0b want 1/1", state, cnt_en);
    end
    repeat (12) @(posedge clk_50M);
    @(negedge clk_50M);
    key_ss_n = 1'b1;
    repeat (14) @(negedge clk_50M);
    n_chk++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL start_single got st=%0d want 1", state);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      key_ss_n = (i % 4) < 2 ? 1'b0 : 1'b1;
      @(negedge clk_50M);
    end
    key_ss_n = 1'b1;
    repeat (14) @(negedge clk_50M);
    n_chk++;
    if (state !== 2'd0 || cnt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce got st=%0d en=%0b want 0/0", state, cnt_en);
    end
  endtask

  task automatic test_lap();
    press(1'b0);
    ms_in = 12'd345;
    sec_in = 8'd12;
    min_in = 4'd3;
    press(1'b1);
    ms_in = 12'd500;
    sec_in = 8'd40;
    min_in = 4'd5;
    @(negedge clk_50M);
    n_chk++;
    if ({disp_ms, disp_sec, disp_min} !== {12'd345, 8'd12, 4'd3}) begin
      n_fail++;
      $display("FAIL lap_freeze got %0d/%0d/%0d want 345/12/3",
               disp_ms, disp_sec, disp_min);
    end
    n_chk++;
    if (state !== 2'd3 || lap_cnt !== 4'd1 || cnt_en !== 1'b1) begin
      n_fail++;
      $display("FAIL lap_state got st=%0d lap=%0d en=%0b want 3/1/1",
               state, lap_cnt, cnt_en);
    end
    press(1'b1);
    ms_in = 12'd777;
    @(negedge clk_50M);
    n_chk++;
    if (state !== 2'd1 || disp_ms !== 12'd777 || disp_sec !== 8'd40) begin
      n_fail++;
      $display("FAIL lap_live got st=%0d ms=%0d sec=%0d want 1/777/40",
               state, disp_ms, disp_sec);
    end
  endtask

  task automatic test_pause_clear();
    int clr_n;
    logic clr_ok;
    press(1'b0);
    n_chk++;
    if (state !== 2'd2 || cnt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pause got st=%0d en=%0b want 2/0", state, cnt_en);
    end
    clr_n = 0;
    clr_ok = 1'b1;
    key_lr_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_50M);
      if (cnt_clr === 1'b1) begin
        clr_n++;
        if (state !== 2'd0 || cnt_en !== 1'b0) clr_ok = 1'b0;
      end
    end
    key_lr_n = 1'b1;
    repeat (8) @(negedge clk_50M);
    n_chk++;
    if (clr_n !== 1 || !clr_ok) begin
      n_fail++;
      $display("FAIL clear_pulse got %0d pulses ok=%0b want 1/1",
               clr_n, clr_ok);
    end
    n_chk++;
    if (state !== 2'd0 || lap_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_state got st=%0d lap=%0d want 0/0",
               state, lap_cnt);
    end
  endtask

  task automatic test_both_keys();
    int clr_n;
    clr_n = 0;
    key_ss_n = 1'b0;
    key_lr_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_50M);
      if (cnt_clr === 1'b1) clr_n++;
    end
    key_ss_n = 1'b1;
    key_lr_n = 1'b1;
    repeat (8) @(negedge clk_50M);
    n_chk++;
    if (state !== 2'd1 || clr_n !== 0) begin
      n_fail++;
      $display("FAIL both_keys got st=%0d clr=%0d want 1/0", state, clr_n);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 14; k++) begin
      press(1'b1);
      press(1'b1);
    end
    n_chk++;
    if (lap_cnt !== 4'd14 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL lap_14 got lap=%0d st=%0d want 14/1", lap_cnt, state);
    end
    for (int k = 0; k < 3; k++) begin
      press(1'b1);
      press(1'b1);
    end
    n_chk++;
    if (lap_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL lap_sat got %0d want 15", lap_cnt);
    end
    ms_in = 12'd999;
    sec_in = 8'd59;
    min_in = 4'd9;
    press(1'b1);
    ms_in = 12'd1;
    @(negedge clk_50M);
    n_chk++;
    if (state !== 2'd3 || lap_cnt !== 4'd15 || disp_ms !== 12'd999) begin
      n_fail++;
      $display("FAIL lap_at_15 got st=%0d lap=%0d ms=%0d want 3/15/999",
               state, lap_cnt, disp_ms);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({state, cnt_en, cnt_clr, lap_cnt} !== 8'h00 || disp_ms !== 12'd1) begin
      n_fail++;
      $display("FAIL rst_in_lap got st=%0d en=%0b lap=%0d ms=%0d want 0/0/0/1",
               state, cnt_en, lap_cnt, disp_ms);
    end
    @(negedge clk_50M);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_bounce();
    test_lap();
    test_pause_clear();
    test_both_keys();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and display-select block for the 50 MHz stopwatch. It debounces the two push-buttons and runs the start/pause/lap/clear state machine. It drives the enable and synchronous clear of the ms/sec/min counter and selects what the 7-segment decode path shows: either the live count or a frozen lap snapshot. It sits between the board keys and the counter/SEG7 decode chain, replacing ad-hoc edge toggling at top level.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level (20 ms at 50 MHz); minimum 2
- clk_50M  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- key_ss_n  input  1  start/stop key, active-low, asynchronous to clk_50M
- key_lr_n  input  1  lap/reset key, active-low, asynchronous to clk_50M
- ms_in  input  12  live counter milliseconds, 0..999
- sec_in  input  8  live counter seconds, 0..59
- min_in  input  4  live counter minutes, 0..9
- cnt_en  output  1  counter run enable
- cnt_clr  output  1  counter synchronous clear, one-cycle pulse
- disp_ms  output  12  milliseconds to display
- disp_sec  output  8  seconds to display
- disp_min  output  4  minutes to display
- state  output  2  IDLE=0, RUN=1, PAUSED=2, LAP=3
- lap_cnt  output  4  laps taken since last clear, saturating

## Operation
- Each key passes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - The debounced level resets to 1 (released).
- A press event is a one-cycle pulse on a debounced 1->0 transition. Releases generate nothing. Only one event per physical press.
- FSM transitions (ss = start/stop event, lr = lap/reset event):
  - IDLE: ss -> RUN. lr -> IDLE, pulse cnt_clr, lap_cnt=0.
  - RUN: ss -> PAUSED. lr -> LAP, capture snapshot, lap_cnt+1.
  - LAP: ss -> PAUSED. lr -> RUN (display returns to live).
  - PAUSED: ss -> RUN. lr -> IDLE, pulse cnt_clr, lap_cnt=0.
- Simultaneous ss and lr events in the same cycle: ss wins, lr is discarded.
- cnt_en = 1 in RUN and LAP. The counter keeps running while a lap is displayed.
- Snapshot capture: snap regs <= {ms_in, sec_in, min_in} sampled on the clock edge on which state becomes LAP.
- disp_* = snapshot registers when state==LAP, otherwise ms_in/sec_in/min_in passed through combinationally.
- lap_cnt saturates at 15. A lap press at 15 still enters LAP and captures the snapshot.
- Inputs are not range-checked. Values are passed through unmodified.

## Timing
- Reset values (immediate on rst, independent of clock):
  - state=IDLE, cnt_en=0, cnt_clr=0, lap_cnt=0.
  - Snapshot registers 0.
  - Both synchronizer stages and both debounced levels 1.
  - Debounce counters 0.
- Key latency: a key held low from before clock edge E0 produces its event pulse on edge E0+DEBOUNCE_CYCLES+2.
  - state/cnt_en/cnt_clr/lap_cnt update on edge E0+DEBOUNCE_CYCLES+3 (all outputs registered).
- cnt_clr is high for exactly one cycle, coincident with the first cycle of state==IDLE after the lr event.
- Entering IDLE from PAUSED: cnt_en is already 0, so the counter sees cnt_clr with cnt_en=0.
- Snapshot and state==LAP become visible on the same edge. disp_* switches to the frozen value in that cycle, with no glitch cycle showing live data.
- rst asserted mid-debounce or mid-LAP aborts everything. A key still held when rst deasserts is seen as a fresh press after DEBOUNCE_CYCLES+3 cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a stub counter.
- Reset, then hold key_ss_n low 20 cycles -> state=1 and cnt_en=1 exactly 7 edges after the first low sample. A single event only.
- key_ss_n toggles low/high every 2 cycles for 30 cycles, then stays high -> no event, state stays IDLE.
- In RUN with ms_in=345, sec_in=12, min_in=3, press lr:
  - disp_* freezes at 345/12/3 while ms_in keeps changing, and lap_cnt=1.
  - A second lr press makes disp follow live again, with state=RUN.
- RUN -> ss (PAUSED, cnt_en=0) -> lr -> state=IDLE, cnt_clr high exactly 1 cycle, lap_cnt=0.
- Both keys pressed on the same cycle in IDLE -> state=RUN, no cnt_clr pulse.
- 17 lap cycles (lr, lr) in RUN -> lap_cnt stops at 15. Assert rst in LAP -> all outputs at reset values within the same cycle.
